// File: rtl/hack_pkg.sv
// hack_pkg: shared state encoding, instruction field positions and jump decode for the Hack core.
package hack_pkg;

    typedef enum logic [1:0] {FETCH, MREAD, EXEC, MWRITE} state_t;

    localparam int IS_C   = 15;
    localparam int A_BIT  = 12;
    localparam int DEST_A = 5;
    localparam int DEST_D = 4;
    localparam int DEST_M = 3;

    // Jump field bits: each one enables a sign class of the ALU result.
    localparam int J_LT = 2;
    localparam int J_EQ = 1;
    localparam int J_GT = 0;

    function automatic logic jump_taken(input logic [2:0] j, input logic zr, input logic ng);
        return (j[J_LT] & ng) | (j[J_EQ] & zr) | (j[J_GT] & ~ng & ~zr);
    endfunction

endpackage

// File: rtl/hack_alu.sv
// hack_alu: combinational Hack ALU with zero/negate conditioning of both operands.
module hack_alu #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    input  logic              zx,
    input  logic              nx,
    input  logic              zy,
    input  logic              ny,
    input  logic              f,
    input  logic              no,
    output logic [DATA_W-1:0] out,
    output logic              zr,
    output logic              ng
);

    logic [DATA_W-1:0] xz, xn, yz, yn, fo;

    assign xz  = zx ? '0 : x;
    assign xn  = nx ? ~xz : xz;
    assign yz  = zy ? '0 : y;
    assign yn  = ny ? ~yz : yz;
    assign fo  = f ? xn + yn : xn & yn;
    assign out = no ? ~fo : fo;
    assign zr  = out == '0;
    assign ng  = out[DATA_W-1];

endmodule

// File: rtl/hack_cpu_mc.sv
// hack_cpu_mc: multi-cycle Hack CPU; fetch and data accesses stall on req/ack handshakes.
module hack_cpu_mc
    import hack_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 15,
    parameter int PC_W     = 15,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [PC_W-1:0]   pc,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] d_out,
    output logic              retire,
    output logic              halted
);

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d, pc_inc;
    logic [DATA_W-1:0]   a_q, a_d, d_q, d_d, m_q, m_d, wdata_q, wdata_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [15:0]         ir_q, ir_d;
    logic                halted_q, halted_d, selfjmp_q, selfjmp_d;
    logic [DATA_W-1:0]   alu_out;
    logic                zr, ng, take;

    hack_alu #(.DATA_W(DATA_W)) u_alu (
        .x(d_q), .y(ir_q[A_BIT] ? m_q : a_q),
        .zx(ir_q[11]), .nx(ir_q[10]), .zy(ir_q[9]), .ny(ir_q[8]), .f(ir_q[7]), .no(ir_q[6]),
        .out(alu_out), .zr(zr), .ng(ng)
    );

    assign pc_inc     = pc_q + PC_W'(1);
    assign take       = jump_taken(ir_q[2:0], zr, ng);
    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign a_out      = a_q;
    assign d_out      = d_q;
    assign dmem_wdata = wdata_q;
    assign halted     = halted_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        a_d       = a_q;
        d_d       = d_q;
        m_d       = m_q;
        ir_d      = ir_q;
        wdata_d   = wdata_q;
        waddr_d   = waddr_q;
        halted_d  = halted_q;
        selfjmp_d = selfjmp_q;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        dmem_addr = a_q[ADDR_W-1:0];
        retire    = 1'b0;
        case (state_q)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = (imem_rdata[IS_C] && imem_rdata[A_BIT]) ? MREAD : EXEC;
                end
            end
            MREAD: begin
                dmem_req = 1'b1;
                if (dmem_ack) begin
                    m_d     = dmem_rdata;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (!ir_q[IS_C]) begin
                    a_d     = DATA_W'(ir_q[IS_C-1:0]);
                    pc_d    = pc_inc;
                    retire  = 1'b1;
                    state_d = FETCH;
                end else begin
                    pc_d      = take ? a_q[PC_W-1:0] : pc_inc;
                    a_d       = ir_q[DEST_A] ? alu_out : a_q;
                    d_d       = ir_q[DEST_D] ? alu_out : d_q;
                    selfjmp_d = take && (a_q[PC_W-1:0] == pc_q);
                    wdata_d   = alu_out;
                    waddr_d   = a_q[ADDR_W-1:0];
                    // A pending M write defers retire (and the halt flag) to MWRITE.
                    retire    = !ir_q[DEST_M];
                    halted_d  = halted_q | (selfjmp_d & !ir_q[DEST_M]);
                    state_d   = ir_q[DEST_M] ? MWRITE : FETCH;
                end
            end
            MWRITE: begin
                dmem_req  = 1'b1;
                dmem_we   = 1'b1;
                dmem_addr = waddr_q;
                if (dmem_ack) begin
                    retire   = 1'b1;
                    halted_d = halted_q | selfjmp_q;
                    state_d  = FETCH;
                end
            end
        endcase
        if (reset) begin
            imem_req = 1'b0;
            dmem_req = 1'b0;
            dmem_we  = 1'b0;
            retire   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            pc_q      <= PC_W'(RESET_PC);
            a_q       <= '0;
            d_q       <= '0;
            m_q       <= '0;
            ir_q      <= '0;
            wdata_q   <= '0;
            waddr_q   <= '0;
            halted_q  <= 1'b0;
            selfjmp_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            a_q       <= a_d;
            d_q       <= d_d;
            m_q       <= m_d;
            ir_q      <= ir_d;
            wdata_q   <= wdata_d;
            waddr_q   <= waddr_d;
            halted_q  <= halted_d;
            selfjmp_q <= selfjmp_d;
        end
    end

endmodule
